// File: rtl/rs_pkg.sv
// Shared types, default widths and the CDB tag-match helper for the reservation station.
// Entry fields are sized from the package defaults; the top-level parameters must match them.
package rs_pkg;

    localparam int unsigned RS_ENTRIES = 4;
    localparam int unsigned RS_OP_W    = 4;
    localparam int unsigned RS_TAG_W   = 4;
    localparam int unsigned RS_VAL_W   = 32;
    localparam int unsigned RS_RANK_W  = $clog2(RS_ENTRIES);

    localparam logic [RS_TAG_W-1:0] TAG_READY = '0;

    typedef struct packed {
        logic                     valid;
        logic [RS_OP_W-1:0]       op;
        logic [1:2][RS_TAG_W-1:0] tag;
        logic [1:2][RS_VAL_W-1:0] val;
        logic [RS_TAG_W-1:0]      target;
        logic [RS_RANK_W-1:0]     rank;
    } rs_entry_t;

    // A pending source captures the broadcast only on a non-zero tag match.
    function automatic logic src_wakes(input logic                cdb_valid,
                                       input logic [RS_TAG_W-1:0] cdb_tag,
                                       input logic [RS_TAG_W-1:0] tag);
        return cdb_valid && (tag != TAG_READY) && (tag == cdb_tag);
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Picks the oldest (minimum-rank) ready entry. Purely combinational.
module rs_age_select #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned RANK_W  = $clog2(ENTRIES),
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0]             ready,
    input  logic [ENTRIES-1:0][RANK_W-1:0] rank,
    output logic [ENTRIES-1:0]             sel_onehot,
    output logic [IDX_W-1:0]               sel_idx,
    output logic                           any_ready
);

    // Ranks of valid entries are unique; the index tie-break keeps the result one-hot regardless.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            sel_onehot[i] = ready[i];
            for (int j = 0; j < ENTRIES; j++) begin
                if (j != i && ready[j] &&
                    ((rank[j] < rank[i]) || ((rank[j] == rank[i]) && (j < i)))) begin
                    sel_onehot[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (sel_onehot[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign any_ready = |ready;

endmodule

// File: rtl/rs_scheduler.sv
// Reservation-station scheduler: buffers issued ops, wakes operands from the CDB and
// dispatches the oldest ready op, holding a presented op stable until the exec unit accepts.
module rs_scheduler
    import rs_pkg::*;
#(
    parameter int unsigned ENTRIES = RS_ENTRIES,
    parameter int unsigned OP_W    = RS_OP_W,
    parameter int unsigned TAG_W   = RS_TAG_W,
    parameter int unsigned VAL_W   = RS_VAL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            in_op,
    input  logic [TAG_W-1:0]           in_tag1,
    input  logic [TAG_W-1:0]           in_tag2,
    input  logic [VAL_W-1:0]           in_val1,
    input  logic [VAL_W-1:0]           in_val2,
    input  logic [TAG_W-1:0]           in_target,

    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [VAL_W-1:0]           cdb_val,

    output logic                       ex_valid,
    input  logic                       ex_ready,
    output logic [OP_W-1:0]            ex_op,
    output logic [VAL_W-1:0]           ex_val1,
    output logic [VAL_W-1:0]           ex_val2,
    output logic [TAG_W-1:0]           ex_target,

    output logic [$clog2(ENTRIES):0]   occupancy
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned OCC_W = $clog2(ENTRIES) + 1;

    rs_entry_t [ENTRIES-1:0] ent_q, ent_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic                    lock_q, lock_d;
    logic [IDX_W-1:0]        lock_idx_q, lock_idx_d;

    logic [ENTRIES-1:0]                ready_vec;
    logic [ENTRIES-1:0][RS_RANK_W-1:0] rank_vec;
    logic [ENTRIES-1:0]                sel_onehot;
    logic [IDX_W-1:0]                  sel_idx;
    logic                              any_ready;
    logic [IDX_W-1:0]                  disp_idx;
    logic [IDX_W-1:0]                  free_idx;
    logic [RS_RANK_W-1:0]              disp_rank;
    logic                              accept;
    logic                              fire;
    logic [1:2][TAG_W-1:0]             in_tag;
    logic [1:2][VAL_W-1:0]             in_val;

    assign in_tag = {in_tag1, in_tag2};
    assign in_val = {in_val1, in_val2};

    always_comb begin
        ready_vec = '0;
        rank_vec  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ready_vec[i] = ent_q[i].valid && (ent_q[i].tag[1] == TAG_READY) &&
                           (ent_q[i].tag[2] == TAG_READY);
            rank_vec[i]  = ent_q[i].rank;
        end
    end

    rs_age_select #(
        .ENTRIES (ENTRIES),
        .RANK_W  (RS_RANK_W),
        .IDX_W   (IDX_W)
    ) u_age_select (
        .ready      (ready_vec),
        .rank       (rank_vec),
        .sel_onehot (sel_onehot),
        .sel_idx    (sel_idx),
        .any_ready  (any_ready)
    );

    // A locked entry stays ready until it dispatches, so the lock alone keeps ex_valid up.
    assign disp_idx  = lock_q ? lock_idx_q : sel_idx;
    assign ex_valid  = lock_q || any_ready;
    assign fire      = ex_valid && ex_ready;
    assign in_ready  = (occ_q != OCC_W'(ENTRIES));
    assign accept    = in_valid && in_ready;
    assign occupancy = occ_q;
    assign disp_rank = ent_q[disp_idx].rank;

    always_comb begin
        ex_op     = '0;
        ex_val1   = '0;
        ex_val2   = '0;
        ex_target = '0;
        if (ex_valid) begin
            ex_op     = ent_q[disp_idx].op;
            ex_val1   = ent_q[disp_idx].val[1];
            ex_val2   = ent_q[disp_idx].val[2];
            ex_target = ent_q[disp_idx].target;
        end
    end

    // Downward scan so the lowest free index is the one left standing.
    always_comb begin
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        ent_d      = ent_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        occ_d      = occ_q + OCC_W'(accept) - OCC_W'(fire);

        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_q[i].valid) begin
                for (int s = 1; s <= 2; s++) begin
                    if (src_wakes(cdb_valid, cdb_tag, ent_q[i].tag[s])) begin
                        ent_d[i].tag[s] = TAG_READY;
                        ent_d[i].val[s] = cdb_val;
                    end
                end
                if (fire && (ent_q[i].rank > disp_rank)) begin
                    ent_d[i].rank = ent_q[i].rank - 1'b1;
                end
                if (fire && (IDX_W'(i) == disp_idx)) begin
                    ent_d[i].valid = 1'b0;
                end
            end
        end

        if (accept) begin
            ent_d[free_idx].valid  = 1'b1;
            ent_d[free_idx].op     = in_op;
            ent_d[free_idx].target = in_target;
            ent_d[free_idx].rank   = RS_RANK_W'(occ_q - OCC_W'(fire));
            for (int s = 1; s <= 2; s++) begin
                if (src_wakes(cdb_valid, cdb_tag, in_tag[s])) begin
                    ent_d[free_idx].tag[s] = TAG_READY;
                    ent_d[free_idx].val[s] = cdb_val;
                end else begin
                    ent_d[free_idx].tag[s] = in_tag[s];
                    ent_d[free_idx].val[s] = in_val[s];
                end
            end
        end

        if (fire) begin
            lock_d = 1'b0;
        end else if (ex_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = disp_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent_q      <= '0;
            occ_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ent_q      <= ent_d;
            occ_q      <= occ_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_rs_scheduler.sv
// Bench for rs_scheduler: a vector table of single-op issues plus hand-built sequences for
// wake-up, lock, full and flush; dispatches are checked against a scoreboard queue.
module tb_rs_scheduler;

    localparam int unsigned ENTRIES = 4;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned VAL_W   = 32;
    localparam int unsigned OCC_W   = $clog2(ENTRIES) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [TAG_W-1:0] in_tag1;
    logic [TAG_W-1:0] in_tag2;
    logic [VAL_W-1:0] in_val1;
    logic [VAL_W-1:0] in_val2;
    logic [TAG_W-1:0] in_target;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [VAL_W-1:0] cdb_val;
    logic             ex_valid;
    logic             ex_ready;
    logic [OP_W-1:0]  ex_op;
    logic [VAL_W-1:0] ex_val1;
    logic [VAL_W-1:0] ex_val2;
    logic [TAG_W-1:0] ex_target;
    logic [OCC_W-1:0] occupancy;

    always #5 clk = ~clk;

    rs_scheduler #(
        .ENTRIES (ENTRIES),
        .OP_W    (OP_W),
        .TAG_W   (TAG_W),
        .VAL_W   (VAL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_tag1   (in_tag1),
        .in_tag2   (in_tag2),
        .in_val1   (in_val1),
        .in_val2   (in_val2),
        .in_target (in_target),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_val   (cdb_val),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_op     (ex_op),
        .ex_val1   (ex_val1),
        .ex_val2   (ex_val2),
        .ex_target (ex_target),
        .occupancy (occupancy)
    );

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [VAL_W-1:0] v1;
        logic [VAL_W-1:0] v2;
        logic [TAG_W-1:0] target;
    } disp_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [TAG_W-1:0] t1;
        logic [TAG_W-1:0] t2;
        logic [VAL_W-1:0] v1;
        logic [VAL_W-1:0] v2;
        logic [TAG_W-1:0] tgt;
        logic             cdb_v;
        logic [TAG_W-1:0] cdb_tag;
        logic [VAL_W-1:0] cdb_val;
    } vec_t;

    disp_t exp_q[$];
    disp_t mon_got;
    disp_t mon_want;
    vec_t  vecs[7];
    int    errors = 0;
    int    checks = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Handshakes complete at the next posedge; compare each one against the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && flush === 1'b0 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dispatch: got target 0x%0h, required no dispatch",
                         ex_target);
            end else begin
                mon_want = exp_q.pop_front();
                mon_got  = '{op: ex_op, v1: ex_val1, v2: ex_val2, target: ex_target};
                check("dispatch", mon_got, mon_want);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_tag1   = '0;
        in_tag2   = '0;
        in_val1   = '0;
        in_val2   = '0;
        in_target = '0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_val   = '0;
    endtask

    task automatic drive_issue(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] t1,
                               input logic [TAG_W-1:0] t2, input logic [VAL_W-1:0] v1,
                               input logic [VAL_W-1:0] v2, input logic [TAG_W-1:0] tgt);
        in_valid  = 1'b1;
        in_op     = op;
        in_tag1   = t1;
        in_tag2   = t2;
        in_val1   = v1;
        in_val2   = v2;
        in_target = tgt;
    endtask

    initial begin
        vecs[0] = '{op: 4'h3, t1: 4'h0, t2: 4'h0, v1: 32'd5, v2: 32'd7, tgt: 4'h9,
                    cdb_v: 1'b0, cdb_tag: 4'h0, cdb_val: 32'h0};
        vecs[1] = '{op: 4'hA, t1: 4'h0, t2: 4'h0, v1: 32'hFFFF_FFFF, v2: 32'h8000_0000,
                    tgt: 4'h1, cdb_v: 1'b1, cdb_tag: 4'h0, cdb_val: 32'hDEAD_BEEF};
        vecs[2] = '{op: 4'h6, t1: 4'h6, t2: 4'h0, v1: 32'hBAD, v2: 32'd2, tgt: 4'h3,
                    cdb_v: 1'b1, cdb_tag: 4'h6, cdb_val: 32'h11};
        vecs[3] = '{op: 4'hC, t1: 4'h0, t2: 4'h9, v1: 32'h44, v2: 32'hBAD, tgt: 4'h4,
                    cdb_v: 1'b1, cdb_tag: 4'h9, cdb_val: 32'h99};
        vecs[4] = '{op: 4'h5, t1: 4'h5, t2: 4'h5, v1: 32'hBAD1, v2: 32'hBAD2, tgt: 4'h7,
                    cdb_v: 1'b1, cdb_tag: 4'h5, cdb_val: 32'h55};
        vecs[5] = '{op: 4'hF, t1: 4'h0, t2: 4'h0, v1: 32'd1, v2: 32'd2, tgt: 4'hF,
                    cdb_v: 1'b1, cdb_tag: 4'h3, cdb_val: 32'h77};
        vecs[6] = '{op: 4'h0, t1: 4'hF, t2: 4'h0, v1: 32'h0, v2: 32'h12, tgt: 4'h2,
                    cdb_v: 1'b1, cdb_tag: 4'hF, cdb_val: 32'hCAFE_0001};

        rst      = 1'b1;
        ex_ready = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_ex_valid", ex_valid, 1'b0);
        check("reset_occupancy", occupancy, 3'd0);
        check("reset_ex_op", ex_op, 4'h0);

        // Single issues, some bypassing a same-cycle broadcast; each dispatches the next cycle.
        ex_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive_issue(vecs[k].op, vecs[k].t1, vecs[k].t2, vecs[k].v1, vecs[k].v2, vecs[k].tgt);
            cdb_valid = vecs[k].cdb_v;
            cdb_tag   = vecs[k].cdb_tag;
            cdb_val   = vecs[k].cdb_val;
            exp_q.push_back('{op: vecs[k].op,
                              v1: (vecs[k].t1 != 4'h0) ? vecs[k].cdb_val : vecs[k].v1,
                              v2: (vecs[k].t2 != 4'h0) ? vecs[k].cdb_val : vecs[k].v2,
                              target: vecs[k].tgt});
            step();
            clear_inputs();
            check($sformatf("vec%0d_ex_valid", k), ex_valid, 1'b1);
            check($sformatf("vec%0d_occ_held", k), occupancy, 3'd1);
            check($sformatf("vec%0d_ex_target", k), ex_target, vecs[k].tgt);
            step();
            check($sformatf("vec%0d_occ_after", k), occupancy, 3'd0);
            check($sformatf("vec%0d_idle_valid", k), ex_valid, 1'b0);
            check($sformatf("vec%0d_idle_op", k), ex_op, 4'h0);
        end

        // Wake-up of one source, no dispatch before the broadcast.
        drive_issue(4'h2, 4'h4, 4'h0, 32'h0, 32'h22, 4'h5);
        step();
        clear_inputs();
        repeat (3) begin
            check("wake_no_early", ex_valid, 1'b0);
            step();
        end
        cdb_valid = 1'b1;
        cdb_tag   = 4'h4;
        cdb_val   = 32'hAA;
        exp_q.push_back('{op: 4'h2, v1: 32'hAA, v2: 32'h22, target: 4'h5});
        check("wake_cdb_cycle", ex_valid, 1'b0);
        step();
        clear_inputs();
        check("wake_ex_valid", ex_valid, 1'b1);
        check("wake_val1", ex_val1, 32'hAA);
        step();
        check("wake_occ", occupancy, 3'd0);

        // Both sources wake on one broadcast.
        drive_issue(4'h8, 4'h3, 4'h3, 32'h0, 32'h0, 4'h6);
        step();
        clear_inputs();
        check("wake2_pending", ex_valid, 1'b0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'h3;
        cdb_val   = 32'h33;
        exp_q.push_back('{op: 4'h8, v1: 32'h33, v2: 32'h33, target: 4'h6});
        step();
        clear_inputs();
        check("wake2_ex_valid", ex_valid, 1'b1);
        step();

        // Oldest-first with lock: B is presented, A wakes later but must wait for B's handshake.
        ex_ready = 1'b0;
        drive_issue(4'h1, 4'h2, 4'h0, 32'h0, 32'hA2, 4'h1);
        step();
        clear_inputs();
        drive_issue(4'h2, 4'h0, 4'h0, 32'hB1, 32'hB2, 4'h2);
        exp_q.push_back('{op: 4'h2, v1: 32'hB1, v2: 32'hB2, target: 4'h2});
        step();
        clear_inputs();
        check("lock_b_presented", ex_target, 4'h2);
        step();
        cdb_valid = 1'b1;
        cdb_tag   = 4'h2;
        cdb_val   = 32'hA1;
        exp_q.push_back('{op: 4'h1, v1: 32'hA1, v2: 32'hA2, target: 4'h1});
        step();
        clear_inputs();
        check("lock_hold_target", ex_target, 4'h2);
        check("lock_hold_val1", ex_val1, 32'hB1);
        step();
        check("lock_hold_again", ex_target, 4'h2);
        ex_ready = 1'b1;
        step();
        check("lock_then_a_target", ex_target, 4'h1);
        check("lock_then_a_val1", ex_val1, 32'hA1);
        step();
        check("lock_drained_occ", occupancy, 3'd0);
        check("lock_drained_valid", ex_valid, 1'b0);

        // Fill under backpressure; a full station refuses even when a dispatch frees a slot.
        ex_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_issue(4'(k + 1), 4'h0, 4'h0, 32'(k * 16 + 3), 32'(k + 100), 4'(k + 8));
            exp_q.push_back('{op: 4'(k + 1), v1: 32'(k * 16 + 3), v2: 32'(k + 100),
                              target: 4'(k + 8)});
            step();
            clear_inputs();
        end
        check("full_in_ready", in_ready, 1'b0);
        check("full_occ", occupancy, 3'd4);
        drive_issue(4'hE, 4'h0, 4'h0, 32'hE1, 32'hE2, 4'hE);
        step();
        clear_inputs();
        check("full_reject_occ", occupancy, 3'd4);
        drive_issue(4'hE, 4'h0, 4'h0, 32'hE1, 32'hE2, 4'hE);
        ex_ready = 1'b1;
        step();
        clear_inputs();
        ex_ready = 1'b0;
        check("full_same_cycle_occ", occupancy, 3'd3);
        check("full_in_ready_back", in_ready, 1'b1);
        check("full_next_oldest", ex_target, 4'h9);

        // Flush with three entries held, colliding with an issue and a broadcast.
        check("pre_flush_pending", exp_q.size(), 3);
        flush = 1'b1;
        drive_issue(4'h7, 4'h0, 4'h0, 32'h70, 32'h71, 4'h7);
        cdb_valid = 1'b1;
        cdb_tag   = 4'h1;
        cdb_val   = 32'h1234;
        step();
        clear_inputs();
        exp_q.delete();
        check("flush_occ", occupancy, 3'd0);
        check("flush_ex_valid", ex_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_ex_target", ex_target, 4'h0);
        step();
        check("flush_stays_idle", ex_valid, 1'b0);

        // Station resumes normally after a flush.
        ex_ready = 1'b1;
        drive_issue(4'h4, 4'h0, 4'h0, 32'h400, 32'h401, 4'h3);
        exp_q.push_back('{op: 4'h4, v1: 32'h400, v2: 32'h401, target: 4'h3});
        step();
        clear_inputs();
        check("post_flush_valid", ex_valid, 1'b1);
        step();
        check("post_flush_occ", occupancy, 3'd0);
        repeat (2) step();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_scheduler.md
Name: rs_scheduler

Overview:
- Reservation-station scheduler for one execution unit, between the ID→EX issue path and that unit.
- Buffers issued ops, snoops the common data bus (CDB) to wake pending operands, and dispatches the oldest fully-ready op with a valid/ready handshake.
- Tag value 0 means "operand value present". Non-zero tags are ROB positions.

Parameters:
- ENTRIES, 4, number of station entries (power of 2, ≥2)
- OP_W, 4, op code width
- TAG_W, 4, ROB tag width (tag 0 reserved as "ready")
- VAL_W, 32, operand/result width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (mispredict recovery)
- in_valid  in  1  issue request
- in_ready  out  1  station can accept
- in_op  in  OP_W  op code
- in_tag1, in_tag2  in  TAG_W  source tags (0 = value present)
- in_val1, in_val2  in  VAL_W  source values, meaningful when matching tag is 0
- in_target  in  TAG_W  destination ROB position
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  producing ROB position (0 ignored)
- cdb_val  in  VAL_W  broadcast result
- ex_valid  out  1  dispatch valid
- ex_ready  in  1  exec unit accepts
- ex_op  out  OP_W  dispatched op
- ex_val1, ex_val2  out  VAL_W  dispatched operands
- ex_target  out  TAG_W  dispatched ROB position
- occupancy  out  $clog2(ENTRIES)+1  occupied entry count

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- rst or flush at an edge: all entries invalid, occupancy 0, dispatch lock cleared. Next cycle: ex_valid=0, in_ready=1.
- flush overrides issue, dispatch and CDB capture in the same cycle.
- ex_op/ex_val*/ex_target drive 0 whenever ex_valid=0.
- Issue:
  - in_ready = (occupancy != ENTRIES), combinational from state.
  - Accept on in_valid && in_ready. Write to the lowest-index free entry at the edge.
  - A full station does not accept, even if a dispatch frees an entry that cycle.
- Issue-cycle bypass: if cdb_valid and cdb_tag == in_tagN (both non-zero), store cdb_val and tag 0 for that source.
- Wake-up: each valid entry source with tag ≠ 0 and tag == cdb_tag while cdb_valid captures cdb_val and clears its tag at the edge. Both sources may wake on the same broadcast.
- Ready: an entry is ready when it is valid and both tags are 0. Ready state is visible the cycle after capture.
- Age:
  - Each entry holds a rank 0..ENTRIES-1, where 0 is oldest.
  - An allocated entry gets rank = occupancy, minus 1 if a dispatch also completes that cycle.
  - On dispatch of rank r, every entry with rank > r decrements.
- Select: combinational pick of the minimum-rank ready entry. ex_valid = any ready entry, or lock held.
- Lock:
  - If ex_valid && !ex_ready, the selected entry index is latched. Outputs stay stable until the handshake, even if an older entry becomes ready.
  - The lock clears on the handshake.
- Dispatch: ex_valid && ex_ready frees the entry at the edge and decrements occupancy. Issue and dispatch in the same cycle leave occupancy unchanged.
- Latency:
  - Issue with both tags 0 at edge N → ex_valid in cycle N+1, assuming no older ready entry.
  - CDB wake-up at edge N → dispatchable in cycle N+1.
- Throughput: 1 issue plus 1 dispatch per cycle.

Decomposition:
- rs_pkg holds:
  - rs_entry_t struct: valid, op, tag[1:2], val[1:2], target, rank
  - TAG_READY = 0
  - default widths
- Sub-module rs_age_select: inputs ready vector and rank array; outputs one-hot/index of the oldest ready entry plus an any-ready flag. Purely combinational.
- Top holds entry storage, CDB compare, allocation, rank update and lock.

Test Plan:
- Ready-op issue: issue op=3, tags 0/0, vals 5/7, target 9 → next cycle ex_valid=1, ex_op=3, ex_val1=5, ex_val2=7, ex_target=9. After the handshake, occupancy=0.
- Wake-up: issue tag1=4, tag2=0, ex_ready=1. Then cdb_valid, cdb_tag=4, cdb_val=0xAA → ex_valid rises the next cycle with ex_val1=0xAA. No dispatch occurs before the broadcast.
- Issue-cycle bypass: in_tag1=6 with cdb_tag=6, cdb_val=0x11 in the same cycle → dispatch next cycle with ex_val1=0x11.
- Oldest-first and lock:
  - Issue A (tag1=2), then B (ready). Hold ex_ready=0 → B presented.
  - Wake A via CDB tag 2 → outputs remain B until the handshake, then A is dispatched.
- Full/backpressure: ex_ready=0, issue 4 ops → in_ready=0, occupancy=4, and a 5th in_valid is not accepted. One handshake → in_ready=1 next cycle.
- Flush mid-operation: 3 entries held, assert flush together with in_valid and cdb_valid → next cycle occupancy=0, ex_valid=0, in_ready=1.
